// File: rtl/memory_cu_pkg.sv
// Shared types and constants for the memory control unit.
//   state_e            : FSM state encoding (IDLE=00, LOAD=01, DONE=10, 11 illegal)
//   NUM_PARAMS_DEFAULT : default number of parameter words per load
//   cnt_width()        : word-counter width for a given NUM_PARAMS (minimum 1)
package memory_cu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned NUM_PARAMS_DEFAULT = 4;

    // Counter width covering 0..n-1; a single word still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_cu_counter.sv
// Word counter for the parameter load sequence.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_c       : synchronous clear (priority over increment)
//   incr_c        : increment by one
//   terminal_c    : high while count == NUM_PARAMS-1
//   count         : current count (only with MEMORY_CU_PARAM_IDX_EN)
// Optional feature macro: MEMORY_CU_PARAM_IDX_EN
module memory_cu_counter
    import memory_cu_pkg::*;
#(
    parameter int unsigned NUM_PARAMS = NUM_PARAMS_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear_c,
    input  logic                              incr_c,
    output logic                              terminal_c
`ifdef MEMORY_CU_PARAM_IDX_EN
    ,
    output logic [cnt_width(NUM_PARAMS)-1:0]  count
`endif
);

    localparam int unsigned CNT_W = cnt_width(NUM_PARAMS);

    logic [CNT_W-1:0] count_q;

    // Count register; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_c) begin
            count_q <= '0;
        end else if (incr_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign terminal_c = (count_q == CNT_W'(NUM_PARAMS - 1));

`ifdef MEMORY_CU_PARAM_IDX_EN
    assign count = count_q;
`endif

endmodule

// File: rtl/memory_cu.sv
// Memory control unit: sequences a burst of NUM_PARAMS write enables to the
// downstream parameter register file on each load request.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : block enable; low forces IDLE and aborts a load
//   load_params       : load request (level)
//   params_reg_enable : high for every LOAD cycle (registered)
//   param_idx         : index of the word being written (only with
//                       MEMORY_CU_PARAM_IDX_EN)
// Optional feature macro: MEMORY_CU_PARAM_IDX_EN
module memory_cu
    import memory_cu_pkg::*;
#(
    parameter int unsigned NUM_PARAMS = NUM_PARAMS_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              load_params,
    output logic                              params_reg_enable
`ifdef MEMORY_CU_PARAM_IDX_EN
    ,
    output logic [cnt_width(NUM_PARAMS)-1:0]  param_idx
`endif
);

    state_e current_state;
    logic   terminal_c;
    logic   incr_c;
    logic   clear_c;

    // The counter only advances inside an enabled LOAD; every other case
    // (including an abort) holds it at zero, so it reads 0 outside LOAD.
    assign incr_c  = enable && (current_state == LOAD) && !terminal_c;
    assign clear_c = !incr_c;

    memory_cu_counter #(
        .NUM_PARAMS (NUM_PARAMS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_c    (clear_c),
        .incr_c     (incr_c),
        .terminal_c (terminal_c)
`ifdef MEMORY_CU_PARAM_IDX_EN
        ,
        .count      (param_idx)
`endif
    );

    // State register with the Moore write enable registered alongside it,
    // so params_reg_enable is high exactly when current_state is LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state     <= IDLE;
            params_reg_enable <= 1'b0;
        end else if (!enable) begin
            current_state     <= IDLE;
            params_reg_enable <= 1'b0;
        end else begin
            case (current_state)
                IDLE: begin
                    if (load_params) begin
                        current_state     <= LOAD;
                        params_reg_enable <= 1'b1;
                    end else begin
                        current_state     <= IDLE;
                        params_reg_enable <= 1'b0;
                    end
                end
                LOAD: begin
                    if (terminal_c) begin
                        current_state     <= DONE;
                        params_reg_enable <= 1'b0;
                    end else begin
                        current_state     <= LOAD;
                        params_reg_enable <= 1'b1;
                    end
                end
                DONE: begin
                    // Wait for the request to drop so a held level cannot
                    // trigger a second burst.
                    current_state     <= load_params ? DONE : IDLE;
                    params_reg_enable <= 1'b0;
                end
                default: begin
                    current_state     <= IDLE;
                    params_reg_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_cu.sv
// Directed testbench for memory_cu (NUM_PARAMS=4 main instance, plus a
// NUM_PARAMS=1 instance sharing the same stimulus).
// Optional feature macro: MEMORY_CU_PARAM_IDX_EN
module tb_memory_cu;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic clk;
    logic rst;
    logic enable;
    logic load_params;
    logic pre4;
    logic pre1;
`ifdef MEMORY_CU_PARAM_IDX_EN
    logic [1:0] idx4;
    logic [0:0] idx1;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    memory_cu #(
        .NUM_PARAMS (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .load_params       (load_params),
        .params_reg_enable (pre4)
`ifdef MEMORY_CU_PARAM_IDX_EN
        ,
        .param_idx         (idx4)
`endif
    );

    memory_cu #(
        .NUM_PARAMS (1)
    ) dut1 (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .load_params       (load_params),
        .params_reg_enable (pre1)
`ifdef MEMORY_CU_PARAM_IDX_EN
        ,
        .param_idx         (idx1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one clock edge, then check the main instance.
    task automatic step(input string tag, input logic en, input logic lp,
                        input logic [1:0] st, input logic pre, input int unsigned idx);
        string t;
        t = $sformatf("%s[st%0d,idx%0d]", tag, st, idx);
        enable      = en;
        load_params = lp;
        @(posedge clk);
        #1;
        check({t, "/state"}, 32'(dut.current_state), 32'(st));
        check({t, "/pre"}, 32'(pre4), 32'(pre));
`ifdef MEMORY_CU_PARAM_IDX_EN
        check({t, "/idx"}, 32'(idx4), 32'(idx));
`endif
    endtask

    // Request held for two sampling edges, four LOAD cycles, DONE, IDLE.
    task automatic run_burst(input string tag);
        step(tag, 1'b1, 1'b1, S_LOAD, 1'b1, 0);
        for (int i = 1; i < 4; i++) begin
            step(tag, 1'b1, (i == 1), S_LOAD, 1'b1, i);
        end
        step(tag, 1'b1, 1'b0, S_DONE, 1'b0, 0);
        step(tag, 1'b1, 1'b0, S_IDLE, 1'b0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        load_params = 1'b0;
        #3;
        check("reset/state", 32'(dut.current_state), 32'(S_IDLE));
        check("reset/pre", 32'(pre4), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal load
        run_burst("normal");

        // Request held for 10 edges: one burst, then parked in DONE
        for (int i = 0; i < 10; i++) begin
            step("held", 1'b1, 1'b1, (i < 4) ? S_LOAD : S_DONE, (i < 4), (i < 4) ? i : 0);
        end
        step("held_rel", 1'b1, 1'b0, S_IDLE, 1'b0, 0);

        // Abort on the second LOAD cycle, then a fresh full burst
        step("abort", 1'b1, 1'b1, S_LOAD, 1'b1, 0);
        step("abort", 1'b1, 1'b1, S_LOAD, 1'b1, 1);
        step("abort_drop", 1'b0, 1'b1, S_IDLE, 1'b0, 0);
        run_burst("reload");

        // Disabled block ignores requests
        step("disabled", 1'b0, 1'b1, S_IDLE, 1'b0, 0);
        step("disabled", 1'b0, 1'b1, S_IDLE, 1'b0, 0);

        // No request for three cycles, then a burst
        for (int i = 0; i < 3; i++) begin
            step("noreq", 1'b1, 1'b0, S_IDLE, 1'b0, 0);
        end
        run_burst("after_noreq");

        // Asynchronous reset mid-LOAD (10 ns pulse, spans a clock edge)
        step("rst_mid", 1'b1, 1'b1, S_LOAD, 1'b1, 0);
        step("rst_mid", 1'b1, 1'b0, S_LOAD, 1'b1, 1);
        #2;
        rst         = 1'b1;
        load_params = 1'b1;
        #1;
        check("rst_async/state", 32'(dut.current_state), 32'(S_IDLE));
        check("rst_async/pre", 32'(pre4), 32'(0));
`ifdef MEMORY_CU_PARAM_IDX_EN
        check("rst_async/idx", 32'(idx4), 32'(0));
`endif
        #9;
        rst = 1'b0;
        #1;
        check("rst_release/state", 32'(dut.current_state), 32'(S_IDLE));
        step("post_rst", 1'b1, 1'b1, S_LOAD, 1'b1, 0);
        step("post_rst", 1'b1, 1'b1, S_LOAD, 1'b1, 1);
        step("post_rst", 1'b1, 1'b0, S_LOAD, 1'b1, 2);
        step("post_rst", 1'b1, 1'b0, S_LOAD, 1'b1, 3);
        step("post_rst", 1'b1, 1'b0, S_DONE, 1'b0, 0);
        step("post_rst", 1'b1, 1'b0, S_IDLE, 1'b0, 0);

        // Single-word instance: LOAD lasts exactly one cycle
        enable      = 1'b1;
        load_params = 1'b1;
        @(posedge clk);
        #1;
        check("np1/load_state", 32'(dut1.current_state), 32'(S_LOAD));
        check("np1/load_pre", 32'(pre1), 32'(1));
`ifdef MEMORY_CU_PARAM_IDX_EN
        check("np1/load_idx", 32'(idx1), 32'(0));
`endif
        load_params = 1'b0;
        @(posedge clk);
        #1;
        check("np1/done_state", 32'(dut1.current_state), 32'(S_DONE));
        check("np1/done_pre", 32'(pre1), 32'(0));
        @(posedge clk);
        #1;
        check("np1/idle_state", 32'(dut1.current_state), 32'(S_IDLE));
        check("np1/idle_pre", 32'(pre1), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
